// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / hazard controller: forwarding select
// codes, stall FSM states and the stall-counter width.
package fwd_pkg;

  // Operand source select for the execute stage
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Load-use stall sequencer states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } hz_state_t;

  // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 3
  localparam int CNT_W = 2;

endpackage

// File: rtl/fwd_sel_gen.sv
// One forwarding select for a single execute-stage source operand.
// A matching ALU result in M beats a matching result in W; a load sitting in
// M cannot forward because its data is not available yet.
module fwd_sel_gen
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rdm,
  input  logic              regwritem,
  input  logic              loadm,
  input  logic [REG_AW-1:0] rdw,
  input  logic              regwritew,
  output fwd_sel_t          sel
);

  logic m_hit;
  logic w_hit;

  assign m_hit = regwritem && !loadm && (rdm != '0) && (rdm == rs);
  assign w_hit = regwritew && (rdw != '0) && (rdw == rs);

  // Priority select: memory stage first, then writeback, else register file
  always_comb begin
    sel = FWD_RF;
    if (m_hit) begin
      sel = FWD_MEM;
    end else if (w_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage pipeline.
// Tracks the destinations of the instructions in M and W with shadow
// registers, produces per-operand forwarding selects, and sequences
// LOAD_LAT-cycle load-use stalls. A resolved branch (FlushReq) wins over a
// load-use stall.
// Optional build macro HAZARD_STATS_EN adds saturating StallCnt / FwdCnt
// event counters; without it those ports and counters do not exist.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] RsD,
  input  logic [NUM_SRC*REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0]         RdE,
  input  logic                      RegWriteE,
  input  logic                      LoadE,
  input  logic                      FlushReq,
  output logic [NUM_SRC*2-1:0]      ForwardE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               StallCnt,
  output logic [31:0]               FwdCnt
`endif
);

  logic [REG_AW-1:0] rdm_reg;
  logic              regwritem_reg;
  logic              loadm_reg;
  logic [REG_AW-1:0] rdw_reg;
  logic              regwritew_reg;

  hz_state_t         state_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [NUM_SRC-1:0] rsd_hit;
  logic               load_use;
  logic               stall_act;

  // Per-operand forwarding select and decode-stage load-use compare
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_sel_t sel;

      fwd_sel_gen #(
        .REG_AW(REG_AW)
      ) u_sel (
        .rs        (RsE[gi*REG_AW +: REG_AW]),
        .rdm       (rdm_reg),
        .regwritem (regwritem_reg),
        .loadm     (loadm_reg),
        .rdw       (rdw_reg),
        .regwritew (regwritew_reg),
        .sel       (sel)
      );

      assign ForwardE[gi*2 +: 2] = rst ? FWD_RF : sel;
      assign rsd_hit[gi]         = (RsD[gi*REG_AW +: REG_AW] == RdE);
    end
  endgenerate

  assign load_use = LoadE && (RdE != '0) && (|rsd_hit);

  // Detect is only honoured in IDLE; in STALL the counter alone decides
  assign stall_act = ((state_reg == ST_STALL) || load_use) && !FlushReq && !rst;

  assign StallF = stall_act;
  assign StallD = stall_act;
  assign FlushD = FlushReq && !rst;
  assign FlushE = (stall_act || FlushReq) && !rst;

  // Shadow pipeline E->M->W; a flushed E slot enters M as a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdm_reg       <= '0;
      regwritem_reg <= 1'b0;
      loadm_reg     <= 1'b0;
      rdw_reg       <= '0;
      regwritew_reg <= 1'b0;
    end else begin
      if (FlushE) begin
        rdm_reg       <= '0;
        regwritem_reg <= 1'b0;
        loadm_reg     <= 1'b0;
      end else begin
        rdm_reg       <= RdE;
        regwritem_reg <= RegWriteE;
        loadm_reg     <= LoadE;
      end
      rdw_reg       <= rdm_reg;
      regwritew_reg <= regwritem_reg;
    end
  end

  // Stall sequencer: detect cycle plus LOAD_LAT-1 STALL cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else if (FlushReq) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (load_use && (LOAD_LAT > 1)) begin
            state_reg <= ST_STALL;
            cnt_reg   <= CNT_W'(LOAD_LAT - 1);
          end
        end
        ST_STALL: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg <= CNT_W'(1)) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] fwd_cnt_reg;

  assign StallCnt = stall_cnt_reg;
  assign FwdCnt   = fwd_cnt_reg;

  // Saturating event counters for stall cycles and forwarding cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      fwd_cnt_reg   <= '0;
    end else begin
      if (StallD && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if ((|ForwardE) && (fwd_cnt_reg != '1)) begin
        fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl. Two instances share stimulus:
// one with LOAD_LAT=2 and one with LOAD_LAT=3. Expected outputs are queued
// when stimulus is driven and compared when the outputs are sampled.
module tb_fwd_hazard_ctrl;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC*REG_AW-1:0] RsD;
  logic [NUM_SRC*REG_AW-1:0] RsE;
  logic [REG_AW-1:0]         RdE;
  logic                      RegWriteE;
  logic                      LoadE;
  logic                      FlushReq;

  logic [3:0] fwd2, fwd3;
  logic       sf2, sd2, fd2, fe2;
  logic       sf3, sd3, fd3, fe3;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc2, fc2, sc3, fc3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       dut3;
    logic [3:0] fwd;
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  fwd_hazard_ctrl #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LOAD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .RsD(RsD), .RsE(RsE), .RdE(RdE),
    .RegWriteE(RegWriteE), .LoadE(LoadE), .FlushReq(FlushReq),
    .ForwardE(fwd2), .StallF(sf2), .StallD(sd2), .FlushD(fd2), .FlushE(fe2)
`ifdef HAZARD_STATS_EN
    , .StallCnt(sc2), .FwdCnt(fc2)
`endif
  );

  fwd_hazard_ctrl #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LOAD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .RsD(RsD), .RsE(RsE), .RdE(RdE),
    .RegWriteE(RegWriteE), .LoadE(LoadE), .FlushReq(FlushReq),
    .ForwardE(fwd3), .StallF(sf3), .StallD(sd3), .FlushD(fd3), .FlushE(fe3)
`ifdef HAZARD_STATS_EN
    , .StallCnt(sc3), .FwdCnt(fc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int rsd1, input int rsd0, input int rse1, input int rse0,
                       input int rde, input bit rwe, input bit lde, input bit frq);
    RsD       = {REG_AW'(rsd1), REG_AW'(rsd0)};
    RsE       = {REG_AW'(rse1), REG_AW'(rse0)};
    RdE       = REG_AW'(rde);
    RegWriteE = rwe;
    LoadE     = lde;
    FlushReq  = frq;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_one(input string tag, input bit d3, input logic [3:0] fwd,
                            input bit sf, input bit sd, input bit fd, input bit fe);
    exp_t e;
    e.dut3 = d3;
    e.fwd  = fwd;
    e.sf   = sf;
    e.sd   = sd;
    e.fd   = fd;
    e.fe   = fe;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic expect_both(input string tag, input logic [3:0] fwd,
                             input bit sf, input bit sd, input bit fd, input bit fe);
    expect_one(tag, 1'b0, fwd, sf, sd, fd, fe);
    expect_one(tag, 1'b1, fwd, sf, sd, fd, fe);
  endtask

  task automatic check_pending();
    exp_t       e;
    string      t;
    logic [3:0] g_fwd;
    logic       g_sf, g_sd, g_fd, g_fe;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      if (e.dut3) begin
        g_fwd = fwd3; g_sf = sf3; g_sd = sd3; g_fd = fd3; g_fe = fe3;
      end else begin
        g_fwd = fwd2; g_sf = sf2; g_sd = sd2; g_fd = fd2; g_fe = fe2;
      end
      $display("txn %-9s lat%0d fwd=%b sf=%b sd=%b fd=%b fe=%b", t, e.dut3 ? 3 : 2,
               g_fwd, g_sf, g_sd, g_fd, g_fe);
      chk({t, "/fwd"},    32'(g_fwd), 32'(e.fwd));
      chk({t, "/stallf"}, 32'(g_sf),  32'(e.sf));
      chk({t, "/stalld"}, 32'(g_sd),  32'(e.sd));
      chk({t, "/flushd"}, 32'(g_fd),  32'(e.fd));
      chk({t, "/flushe"}, 32'(g_fe),  32'(e.fe));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_pending();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    // Reset holds every output low even with hazards present
    drive(3, 0, 3, 3, 3, 1'b1, 1'b1, 1'b0);
    expect_both("rst_lu", 4'b0000, 0, 0, 0, 0);
    #1;
    check_pending();
    drive(3, 0, 3, 3, 3, 1'b1, 1'b1, 1'b1);
    expect_both("rst_fl", 4'b0000, 0, 0, 0, 0);
    #1;
    check_pending();
`ifdef HAZARD_STATS_EN
    chk("rst_stallcnt", sc3, 32'd0);
    chk("rst_fwdcnt", fc3, 32'd0);
`endif
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;

    idle();
    expect_both("reset", 4'b0000, 0, 0, 0, 0);
    cycle();

    // ALU writer forwarded from M, then from W
    drive(0, 0, 0, 0, 5, 1'b1, 1'b0, 1'b0);
    expect_both("a_wr", 4'b0000, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 5, 0, 1'b0, 1'b0, 1'b0);
    expect_both("a_mem", 4'b0010, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 5, 0, 1'b0, 1'b0, 1'b0);
    expect_both("a_wb", 4'b0001, 0, 0, 0, 0);
    cycle();

    // Writer two ahead -> WB on operand 1; same rd in M and W -> MEM
    drive(0, 0, 0, 0, 7, 1'b1, 1'b0, 1'b0);
    expect_both("b_wr", 4'b0000, 0, 0, 0, 0);
    cycle();
    idle();
    expect_both("b_gap", 4'b0000, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 7, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_both("b_wb", 4'b0100, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 7, 1'b1, 1'b0, 1'b0);
    expect_both("b_wr2", 4'b0000, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 7, 1'b1, 1'b0, 1'b0);
    expect_both("b_wr3", 4'b0000, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 7, 7, 0, 1'b0, 1'b0, 1'b0);
    expect_both("b_mw", 4'b1010, 0, 0, 0, 0);
    cycle();

    // A load in M is not forwarded; once in W it is
    drive(0, 0, 0, 0, 9, 1'b1, 1'b1, 1'b0);
    expect_both("l_ld", 4'b0000, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 9, 0, 1'b0, 1'b0, 1'b0);
    expect_both("l_m", 4'b0000, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 9, 0, 1'b0, 1'b0, 1'b0);
    expect_both("l_w", 4'b0001, 0, 0, 0, 0);
    cycle();

    // Load-use on RsD[1]: stall 2 cycles (LOAD_LAT=2) and 3 cycles (LOAD_LAT=3)
    drive(3, 0, 0, 0, 3, 1'b1, 1'b1, 1'b0);
    expect_both("c_det", 4'b0000, 1, 1, 0, 1);
    cycle();
    drive(3, 0, 0, 0, 3, 1'b1, 1'b1, 1'b0);
    expect_both("c_s1", 4'b0000, 1, 1, 0, 1);
    cycle();
    idle();
    expect_one("c_s2", 1'b0, 4'b0000, 0, 0, 0, 0);
    expect_one("c_s2", 1'b1, 4'b0000, 1, 1, 0, 1);
    cycle();
    idle();
    expect_both("c_s3", 4'b0000, 0, 0, 0, 0);
    cycle();

    // Register 0 never forwards and a load to r0 never stalls
    drive(0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    expect_both("d_r0", 4'b0000, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    expect_both("d_ld0", 4'b0000, 0, 0, 0, 0);
    cycle();
    idle();
    expect_both("d_after", 4'b0000, 0, 0, 0, 0);
    cycle();

    // Flush beats a simultaneous load-use detect
    drive(0, 4, 0, 0, 4, 1'b1, 1'b1, 1'b1);
    expect_both("e_flush", 4'b0000, 0, 0, 1, 1);
    cycle();
    idle();
    expect_both("e_next", 4'b0000, 0, 0, 0, 0);
    cycle();

    // Asynchronous reset in the middle of a stall
    drive(3, 0, 0, 0, 3, 1'b1, 1'b1, 1'b0);
    expect_both("f_det", 4'b0000, 1, 1, 0, 1);
    cycle();
    idle();
    #1;
    expect_both("f_stall", 4'b0000, 1, 1, 0, 1);
    check_pending();
    #1;
    rst = 1'b1;
    drive(3, 0, 3, 3, 3, 1'b1, 1'b1, 1'b1);
    #1;
    expect_both("f_rst", 4'b0000, 0, 0, 0, 0);
    check_pending();
`ifdef HAZARD_STATS_EN
    chk("f_stallcnt2", sc2, 32'd0);
    chk("f_stallcnt3", sc3, 32'd0);
    chk("f_fwdcnt3", fc3, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    expect_both("f_after", 4'b0000, 0, 0, 0, 0);
    cycle();
    idle();
    expect_both("f_after2", 4'b0000, 0, 0, 0, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of source operands per instruction (1..3).
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (1..3).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port RsD  input  NUM_SRC*REG_AW  decode-stage source registers, operand i at bits [i*REG_AW +: REG_AW].
REQ-007 SHALL have port RsE  input  NUM_SRC*REG_AW  execute-stage source registers, same packing as RsD.
REQ-008 SHALL have port RdE  input  REG_AW  execute-stage destination register.
REQ-009 SHALL have port RegWriteE  input  1  execute-stage instruction writes the register file.
REQ-010 SHALL have port LoadE  input  1  execute-stage instruction is a load.
REQ-011 SHALL have port FlushReq  input  1  taken branch or jump resolved in execute.
REQ-012 SHALL have port ForwardE  output  NUM_SRC*2  per-operand select: 00 register file, 01 writeback, 10 memory stage.
REQ-013 SHALL have ports StallF, StallD, FlushD, FlushE  output  1 each  pipeline control.

Function
REQ-014 SHALL keep internal shadow registers RdM, RegWriteM, LoadM, then RdW, RegWriteW, advancing every cycle.
REQ-015 SHALL load a bubble (RegWriteM=0, LoadM=0, RdM=0) into the M shadow stage when FlushE is high, and the E contents otherwise.
REQ-016 SHALL drive ForwardE[i]=10 when RegWriteM, LoadM=0, RdM!=0 and RdM==RsE[i].
REQ-017 SHALL otherwise drive ForwardE[i]=01 when RegWriteW, RdW!=0 and RdW==RsE[i]; M match has priority over W.
REQ-018 SHALL otherwise drive ForwardE[i]=00; code 11 SHALL never be produced.
REQ-019 SHALL generate ForwardE combinationally from the shadow registers and RsE, with zero latency.
REQ-020 SHALL detect load-use when LoadE, RdE!=0 and RdE matches any RsD[i].
REQ-021 SHALL implement FSM IDLE/STALL with counter: IDLE->STALL on load-use with count=LOAD_LAT-1; STALL decrements, exits to IDLE at 0.
REQ-022 SHALL assert StallF, StallD and FlushE combinationally in the detect cycle and in every STALL cycle; total stall length SHALL be exactly LOAD_LAT cycles.
REQ-023 SHALL assert FlushD and FlushE in the cycle FlushReq is high.
REQ-024 SHALL give FlushReq priority over a simultaneous load-use detect: StallF=StallD=0 and the FSM forced to IDLE.
REQ-025 SHALL ignore load-use detection while in STALL; the counter alone ends the stall.

Reset
REQ-026 SHALL on rst clear all shadow registers to 0, FSM to IDLE and counter to 0, immediately and independent of clk.
REQ-027 SHALL hold ForwardE=0 and StallF=StallD=FlushD=FlushE=0 while rst is high; rst during STALL SHALL abort the stall.

Configuration
REQ-028 SHALL, with HAZARD_STATS_EN defined, add outputs StallCnt and FwdCnt, 32 bits each, saturating at all-ones, cleared by rst.
REQ-029 SHALL increment StallCnt once per cycle StallD is high, and FwdCnt once per cycle any ForwardE[i] is nonzero.
REQ-030 SHALL, without HAZARD_STATS_EN, omit these ports and the counter logic entirely.

Structure
REQ-031 SHALL take fwd_sel_t (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the FSM state enum from shared package fwd_pkg.
REQ-032 SHALL instantiate sub-module fwd_sel_gen once per operand via generate loop, computing one ForwardE field.

Verification
REQ-033 SHALL test: RdE=5/RegWriteE=1 non-load, next cycle RsE[0]=5 -> ForwardE[1:0]=10.
REQ-034 SHALL test: rd=7 writer two cycles ahead with RsE[1]=7 -> ForwardE[3:2]=01; the same rd in M and W -> 10.
REQ-035 SHALL test: LoadE=1/RdE=3 with RsD[1]=3 and LOAD_LAT=2 -> StallD high exactly 2 cycles and FlushE high for the same 2 cycles.
REQ-036 SHALL test: RdE=0 with RegWriteE=1 and RsE=0 -> ForwardE=00; load with RdE=0 -> no stall.
REQ-037 SHALL test: load-use detect and FlushReq in the same cycle -> FlushD=FlushE=1, StallD=0, FSM IDLE next cycle.
REQ-038 SHALL test: rst asserted mid-STALL at LOAD_LAT=3 -> all outputs 0 asynchronously; with HAZARD_STATS_EN, StallCnt=0 after reset.
